rob_snoop_rs: RTL and testbench

- Reservation station for the ALU path. It is the consumer end of the ROB result broadcast.
- Accepts dispatched ops from the ID/IDEX side. Holds them until both source operands are available, snooping the ROB broadcast to capture pending operands by ROB tag.
- Issues the oldest ready op to EX through a valid/ready handshake.
- Sits between IDEX and the EX ALU, alongside the ROB broadcast interface.

---
 rtl/rob_snoop_rs.sv | 188 ++++++++++++++++++
 tb/tb_rob_snoop_rs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_snoop_rs.sv
// ALU reservation station: age-ordered compacting queue that snoops the ROB result
// broadcast and issues the oldest ready op through a one-stage issue register.
// Optional: define RS_ISSUE_BYPASS_EN to let a fully ready dispatch load the issue register directly.
module rob_snoop_rs #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic [OP_W-1:0]                    disp_op,
    input  logic [TAG_W-1:0]                   disp_dest_tag,
    input  logic                               disp_src1_rdy,
    input  logic                               disp_src2_rdy,
    input  logic [DATA_W-1:0]                  disp_src1_val,
    input  logic [DATA_W-1:0]                  disp_src2_val,
    input  logic [TAG_W-1:0]                   disp_src1_tag,
    input  logic [TAG_W-1:0]                   disp_src2_tag,
    input  logic                               bc_valid,
    input  logic [TAG_W-1:0]                   bc_tag,
    input  logic [DATA_W-1:0]                  bc_data,
    input  logic                               flush,
    output logic                               iss_valid,
    input  logic                               iss_ready,
    output logic [OP_W-1:0]                    iss_op,
    output logic [TAG_W-1:0]                   iss_dest_tag,
    output logic [DATA_W-1:0]                  iss_src1,
    output logic [DATA_W-1:0]                  iss_src2,
    output logic [$clog2(ENTRIES+1)-1:0]       occupancy
);

    localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic              s1_rdy;
        logic [DATA_W-1:0] s1_val;
        logic [TAG_W-1:0]  s1_tag;
        logic              s2_rdy;
        logic [DATA_W-1:0] s2_val;
        logic [TAG_W-1:0]  s2_tag;
    } ent_t;

    ent_t              ent_q [ENTRIES];
    ent_t              ent_d [ENTRIES];
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_rm;
    logic              iss_valid_q, iss_valid_d;
    logic [OP_W-1:0]   iss_op_q, iss_op_d;
    logic [TAG_W-1:0]  iss_dest_q, iss_dest_d;
    logic [DATA_W-1:0] iss_src1_q, iss_src1_d;
    logic [DATA_W-1:0] iss_src2_q, iss_src2_d;

    logic              any_rdy, iss_free, do_issue, disp_fire, disp_wr, byp;
    logic [IDX_W-1:0]  sel;
    ent_t              disp_ent;

    // Capture a matching broadcast into any source still waiting on it.
    function automatic ent_t wake(input ent_t e, input logic v, input logic [TAG_W-1:0] t,
                                  input logic [DATA_W-1:0] d);
        ent_t r;
        r = e;
        if (v && !e.s1_rdy && (e.s1_tag == t)) begin
            r.s1_rdy = 1'b1;
            r.s1_val = d;
        end
        if (v && !e.s2_rdy && (e.s2_tag == t)) begin
            r.s2_rdy = 1'b1;
            r.s2_val = d;
        end
        return r;
    endfunction

    assign disp_ready = (cnt_q < CNT_W'(ENTRIES));
    assign iss_free   = !iss_valid_q || iss_ready;
    assign disp_fire  = disp_valid && disp_ready;
    assign do_issue   = iss_free && any_rdy;
    assign cnt_rm     = cnt_q - CNT_W'(do_issue);
    assign disp_wr    = disp_fire && !byp;

    always_comb begin
        disp_ent = ent_t'{disp_op, disp_dest_tag, disp_src1_rdy, disp_src1_val, disp_src1_tag,
                          disp_src2_rdy, disp_src2_val, disp_src2_tag};
        disp_ent = wake(disp_ent, bc_valid, bc_tag, bc_data);
    end

`ifdef RS_ISSUE_BYPASS_EN
    assign byp = disp_fire && iss_free && !any_rdy && disp_ent.s1_rdy && disp_ent.s2_rdy;
`else
    assign byp = 1'b0;
`endif

    // Oldest entry whose operands were both ready at the start of the cycle.
    always_comb begin
        any_rdy = 1'b0;
        sel     = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!any_rdy && (CNT_W'(i) < cnt_q) && ent_q[IDX_W'(i)].s1_rdy
                && ent_q[IDX_W'(i)].s2_rdy) begin
                any_rdy = 1'b1;
                sel     = IDX_W'(i);
            end
        end
    end

    // Shift out the issued entry, wake at post-shift positions, append the dispatch.
    always_comb begin
        for (int unsigned j = 0; j < ENTRIES; j++) begin
            if (do_issue && (IDX_W'(j) >= sel) && (j < ENTRIES - 1)) begin
                ent_d[j] = ent_q[IDX_W'(j + 1)];
            end else begin
                ent_d[j] = ent_q[IDX_W'(j)];
            end
            if (CNT_W'(j) < cnt_rm) begin
                ent_d[j] = wake(ent_d[j], bc_valid, bc_tag, bc_data);
            end
            if (disp_wr && (CNT_W'(j) == cnt_rm)) begin
                ent_d[j] = disp_ent;
            end
        end
        cnt_d = cnt_rm + CNT_W'(disp_wr);
        if (flush) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_dest_d  = iss_dest_q;
        iss_src1_d  = iss_src1_q;
        iss_src2_d  = iss_src2_q;
        if (do_issue) begin
            iss_valid_d = 1'b1;
            iss_op_d    = ent_q[sel].op;
            iss_dest_d  = ent_q[sel].dest;
            iss_src1_d  = ent_q[sel].s1_val;
            iss_src2_d  = ent_q[sel].s2_val;
        end else if (byp) begin
            iss_valid_d = 1'b1;
            iss_op_d    = disp_ent.op;
            iss_dest_d  = disp_ent.dest;
            iss_src1_d  = disp_ent.s1_val;
            iss_src2_d  = disp_ent.s2_val;
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end
        if (flush) begin
            iss_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_dest_q  <= '0;
            iss_src1_q  <= '0;
            iss_src2_q  <= '0;
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                ent_q[j] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_dest_q  <= iss_dest_d;
            iss_src1_q  <= iss_src1_d;
            iss_src2_q  <= iss_src2_d;
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                ent_q[j] <= ent_d[j];
            end
        end
    end

    assign occupancy    = cnt_q;
    assign iss_valid    = iss_valid_q;
    assign iss_op       = iss_op_q;
    assign iss_dest_tag = iss_dest_q;
    assign iss_src1     = iss_src1_q;
    assign iss_src2     = iss_src2_q;

endmodule

// File: tb/tb_rob_snoop_rs.sv
// Scoreboard bench for rob_snoop_rs: directed dispatch/broadcast vectors, expected
// issues queued by the stimulus and popped by a monitor on each accepted issue.
module tb_rob_snoop_rs;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 6;
`ifdef RS_ISSUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic              clk, rst;
    logic              disp_valid, disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_dest_tag;
    logic              disp_src1_rdy, disp_src2_rdy;
    logic [DATA_W-1:0] disp_src1_val, disp_src2_val;
    logic [TAG_W-1:0]  disp_src1_tag, disp_src2_tag;
    logic              bc_valid;
    logic [TAG_W-1:0]  bc_tag;
    logic [DATA_W-1:0] bc_data;
    logic              flush;
    logic              iss_valid, iss_ready;
    logic [OP_W-1:0]   iss_op;
    logic [TAG_W-1:0]  iss_dest_tag;
    logic [DATA_W-1:0] iss_src1, iss_src2;
    logic [$clog2(ENTRIES+1)-1:0] occupancy;

    rob_snoop_rs #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_dest_tag(disp_dest_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
        .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_dest_tag(iss_dest_tag), .iss_src1(iss_src1), .iss_src2(iss_src2),
        .occupancy(occupancy)
    );

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_iss(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                              input logic [DATA_W-1:0] s1, input logic [DATA_W-1:0] s2);
        exp_t e;
        e = '{op: op, tag: tag, s1: s1, s2: s2};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                        input logic r1, input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] t1,
                        input logic r2, input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] t2);
        disp_valid    = 1'b1;
        disp_op       = op;
        disp_dest_tag = tag;
        disp_src1_rdy = r1;
        disp_src1_val = v1;
        disp_src1_tag = t1;
        disp_src2_rdy = r2;
        disp_src2_val = v2;
        disp_src2_tag = t2;
    endtask

    task automatic bcast(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        bc_valid = v;
        bc_tag   = t;
        bc_data  = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; iss_ready = 1'b1;
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 1'b0;
        bcast(1'b0, 0, 0);

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst && iss_valid && iss_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_issue: got tag %0d op 0x%0h, required no issue",
                                     iss_dest_tag, iss_op);
                        end else begin
                            e = exp_q.pop_front();
                            if ({iss_op, iss_dest_tag, iss_src1, iss_src2} !== e) begin
                                errors++;
                                $display("FAIL issue_payload: got op 0x%0h tag %0d s1 0x%0h s2 0x%0h, required op 0x%0h tag %0d s1 0x%0h s2 0x%0h",
                                         iss_op, iss_dest_tag, iss_src1, iss_src2, e.op, e.tag, e.s1, e.s2);
                            end
                        end
                    end
                end
            end
        join_none

        tick(); tick();
        rst = 1'b0;
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_disp_ready", 32'(disp_ready), 1);
        chk("rst_iss_valid", 32'(iss_valid), 0);
        chk("rst_iss_src1", iss_src1, 0);

        // Both operands ready: latency check.
        disp(6'h11, 3'd2, 1'b1, 32'h5, 0, 1'b1, 32'h7, 0);
        expect_iss(6'h11, 3'd2, 32'h5, 32'h7);
        tick();
        disp_valid = 1'b0;
        chk("lat_edge_n_valid", 32'(iss_valid), 32'(BYP));
        chk("lat_edge_n_occ", 32'(occupancy), BYP ? 0 : 1);
        tick();
        chk("lat_edge_n1_valid", 32'(iss_valid), BYP ? 0 : 1);
        tick(); tick();

        // Younger ready op overtakes older pending one; older wakes via broadcast.
        disp(6'h21, 3'd1, 1'b0, 0, 3'd4, 1'b1, 32'h10, 0);
        tick();
        disp(6'h23, 3'd3, 1'b1, 32'h30, 0, 1'b1, 32'h31, 0);
        expect_iss(6'h23, 3'd3, 32'h30, 32'h31);
        expect_iss(6'h21, 3'd1, 32'hAB, 32'h10);
        tick();
        disp_valid = 1'b0;
        bcast(1'b1, 3'd4, 32'hAB);
        tick();
        bcast(1'b0, 0, 0);
        tick(); tick(); tick();

        // Dispatch-time broadcast bypass.
        disp(6'h2A, 3'd5, 1'b1, 32'h44, 0, 1'b0, 32'hDEAD, 3'd6);
        bcast(1'b1, 3'd6, 32'h99);
        expect_iss(6'h2A, 3'd5, 32'h44, 32'h99);
        tick();
        disp_valid = 1'b0;
        bcast(1'b0, 0, 0);
        tick(); tick(); tick();

        // Fill with pending ops, then drain.
        for (int k = 0; k < 4; k++) begin
            disp(6'(6'h30 + k), 3'(k), 1'b0, 0, (k == 0) ? 3'd4 : 3'd5, 1'b1, 32'(32'h100 + k), 0);
            tick();
        end
        chk("full_occupancy", 32'(occupancy), 4);
        chk("full_disp_ready", 32'(disp_ready), 0);
        disp(6'h3F, 3'd6, 1'b1, 32'h1, 0, 1'b1, 32'h2, 0);
        tick();
        chk("full_ignored_1", 32'(occupancy), 4);
        tick();
        chk("full_ignored_2", 32'(occupancy), 4);
        disp_valid = 1'b0;
        bcast(1'b1, 3'd4, 32'h55);
        expect_iss(6'h30, 3'd0, 32'h55, 32'h100);
        tick();
        bcast(1'b0, 0, 0);
        chk("woken_not_issued_occ", 32'(occupancy), 4);
        tick();
        chk("after_remove_occ", 32'(occupancy), 3);
        chk("after_remove_ready", 32'(disp_ready), 1);
        bcast(1'b1, 3'd5, 32'h66);
        expect_iss(6'h31, 3'd1, 32'h66, 32'h101);
        expect_iss(6'h32, 3'd2, 32'h66, 32'h102);
        expect_iss(6'h33, 3'd3, 32'h66, 32'h103);
        tick();
        bcast(1'b0, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("drained_occ", 32'(occupancy), 0);

        // Stall holds the payload; flush clears everything and drops the dispatch.
        iss_ready = 1'b0;
        disp(6'h01, 3'd2, 1'b1, 32'h1, 0, 1'b1, 32'h2, 0);
        tick();
        disp(6'h02, 3'd3, 1'b1, 32'h3, 0, 1'b1, 32'h4, 0);
        tick();
        disp_valid = 1'b0;
        chk("stall_occ", 32'(occupancy), 1);
        chk("stall_valid", 32'(iss_valid), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_hold_valid", 32'(iss_valid), 1);
            chk("stall_hold_tag", 32'(iss_dest_tag), 2);
            chk("stall_hold_op", 32'(iss_op), 1);
            chk("stall_hold_src1", iss_src1, 32'h1);
            chk("stall_hold_src2", iss_src2, 32'h2);
        end
        flush = 1'b1;
        disp(6'h03, 3'd4, 1'b1, 32'h5, 0, 1'b1, 32'h6, 0);
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        chk("flush_occ", 32'(occupancy), 0);
        chk("flush_valid", 32'(iss_valid), 0);
        iss_ready = 1'b1;
        tick(); tick();
        chk("flush_dropped_occ", 32'(occupancy), 0);
        chk("flush_dropped_valid", 32'(iss_valid), 0);

        // Asynchronous reset with three entries plus a held issue.
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(6'(6'h10 + k), 3'(k), 1'b1, 32'(k), 0, 1'b1, 32'(k + 1), 0);
            tick();
        end
        disp_valid = 1'b0;
        chk("prerst_occ", 32'(occupancy), 3);
        chk("prerst_valid", 32'(iss_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_occ", 32'(occupancy), 0);
        chk("async_rst_ready", 32'(disp_ready), 1);
        chk("async_rst_valid", 32'(iss_valid), 0);
        tick();
        rst = 1'b0;
        iss_ready = 1'b1;
        tick(); tick();
        chk("post_rst_valid", 32'(iss_valid), 0);
        chk("post_rst_occ", 32'(occupancy), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
